data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the single-cycle MIPS core: it serves the core's data port (`mem_addr`, `mem_data_in`, `mem_write_en`, `mem_data_out`) with combinational reads and clocked byte-lane writes. After the core halts, an optional dump engine streams the whole memory out over a valid/ready port to the testbench or host. It sits beside the core inside the MIPS machine, opposite the core's data-access initiator.

## Interface
- `WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `AW`, $clog2(WORDS): word-index width (derived).

- `clk`  in  1  rising-edge clock.
- `rst_b`  in  1  reset. **Synchronous, active-high**: asserted = 1, sampled on `clk`.
- `mem_addr`  in  32  byte address from the core's ALU result.
- `mem_data_in`  in  8 x [0:3]  write data; lane 0 = MSB = byte at addr+0 (big-endian).
- `mem_write_en`  in  1  write strobe.
- `mem_data_out`  out  8 x [0:3]  read data, same lane order.
- `halted`  in  1  core halt flag; level, stays high once set.
- `misalign_err`  out  1  sticky misaligned-write flag.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  dump consumer accepts.
- `dump_addr`  out  32  byte address of the dump word.
- `dump_data`  out  32  dump word, lane 0 in bits [31:24].
- `dump_done`  out  1  dump complete.

## Operation
- Word index = `mem_addr[AW+1:2]`. Upper bits are ignored, so addresses alias modulo 4*WORDS.
- **Read:** combinational. `mem_data_out` = array[index] for any `mem_addr`. The core drives `mem_addr` on every instruction, so a misaligned read returns the aligned word and raises no error.
- **Write:** on a `clk` edge with `mem_write_en`=1, `halted`=0, `rst_b`=0 and `mem_addr[1:0]`=0, all four lanes are written.
- **Misaligned write** (`mem_addr[1:0]`≠0 with a write strobe): the write is suppressed and `misalign_err` is set. It stays set until reset.
- **Writes while halted:** ignored, no error.
- **Dump FSM** states:
  - IDLE → DUMP when `halted`=1 is sampled.
  - DUMP: presents word `ptr`. On `dump_valid && dump_ready`, `ptr` increments. The handshake on `ptr`=WORDS-1 moves the FSM to DONE.
  - DONE: holds until reset.
- `dump_valid` = (state==DUMP). While it is high and `dump_ready` is low, `dump_addr`, `dump_data` and `dump_valid` stay stable.
- `dump_addr` = {ptr, 2'b00}, zero-extended.
- `dump_done` = (state==DONE).

## Timing
- **Reset** (edge with `rst_b`=1) produces:
  - all words 0
  - state IDLE, `ptr`=0
  - `misalign_err`=0, `dump_valid`=0, `dump_done`=0
  - `mem_data_out`=0
- Reset mid-dump aborts the dump and returns to IDLE.
- **Write latency:** data written at edge N is visible on `mem_data_out` after edge N. A same-address read in the writing cycle returns the old data.
- **Halt latency:** `halted` first sampled high at edge N. A write presented in cycle N-1 (before that edge) commits, because `halted` was still 0. The FSM enters DUMP at edge N, so `dump_valid`=1 in cycle N+1.
- **Throughput:** one word per cycle with `dump_ready` held high, so a full dump takes WORDS cycles. `dump_done` rises at the edge after the last handshake.
- **Simultaneous reset and halt:** reset wins.
- **Simultaneous write and misalign:** the error is set and memory is unchanged.

## Configuration
- `DMEM_DUMP_EN` **defined:** the dump FSM, counter and dump outputs are as specified above.
- `DMEM_DUMP_EN` **undefined:** no FSM or counter.
  - `dump_valid`=0, `dump_addr`=0, `dump_data`=0.
  - `dump_done` = registered `halted`: 0 after reset, 1 the edge after `halted` is sampled high.
  - `dump_ready` is ignored.

## Structure
- **Package `dmem_pkg`:**
  - `dump_state_t` enum {IDLE, DUMP, DONE}
  - `DMEM_DEFAULT_WORDS`=256
  - `byte_lanes_t` typedef (8-bit x 4)
- **Sub-module `dmem_dump_fsm`:** state, `ptr` counter and handshake. It exposes `ptr` and state to the top, and the top muxes the array read.
- The array and write logic live in the top.

## Test plan
- **Reset then read:** assert reset, read addr 0x10 → `mem_data_out`={00,00,00,00}, all flags 0.
- **Aligned write/read:** write {DE,AD,BE,EF} at 0x08, then read 0x08 → DEADBEEF. Read 0x0A → DEADBEEF, `misalign_err`=0.
- **Misaligned write:**
  - write 0x12345678 at 0x0D → word 0x0C unchanged, `misalign_err`=1 next cycle.
  - a later aligned write still works and the flag stays 1.
- **Aliasing (WORDS=256):** write 0xCAFEF00D at 0x400 → read 0x000 returns 0xCAFEF00D.
- **Dump with backpressure:**
  - preload words 0..3 = 1..4, write in the cycle before `halted` rises, then raise `halted`. `dump_valid` comes up one cycle later.
  - toggle `dump_ready` 1,0,1 → words appear in order with addresses 0,4,8… and values stay stable while stalled.
  - `dump_done`=1 the edge after word WORDS-1; the pre-halt write appears in the dump.
- **Reset mid-dump:** assert reset with `ptr`=5 → next cycle state IDLE, `dump_valid`=0, memory all 0. Re-raising `halted` restarts the dump at address 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the MIPS data-memory responder.
//   dump_state_t       : dump engine states
//   DMEM_DEFAULT_WORDS : default memory depth in 32-bit words
//   byte_lanes_t       : 4 x 8-bit lanes, lane 0 is the MSB (big-endian byte at addr+0)
package dmem_pkg;
  localparam int unsigned DMEM_DEFAULT_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } dump_state_t;

  typedef logic [0:3][7:0] byte_lanes_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// Bus bundle between the responder and its users.
//   Core data port : mem_addr, mem_data_in, mem_write_en -> responder; mem_data_out <- responder
//   Dump port      : dump_ready -> responder; dump_valid, dump_addr, dump_data, dump_done <- responder
// Modports: master (core / host side), slave (responder side).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic [31:0] mem_addr;
  byte_lanes_t mem_data_in;
  logic        mem_write_en;
  byte_lanes_t mem_data_out;

  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  modport master (
    output mem_addr, mem_data_in, mem_write_en, dump_ready,
    input  mem_data_out, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en, dump_ready,
    output mem_data_out, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/data_mem_responder_dump_fsm.sv
// Dump engine for the data memory: walks ptr from 0 to WORDS-1 once the core
// has halted, advancing on each valid/ready handshake, then parks in DONE.
// Ports:
//   clk, rst_b  : clock, synchronous active-high reset
//   halted      : core halt level, starts the dump
//   dump_ready  : consumer accepts the current word
//   state       : current dump state (top derives dump_valid / dump_done)
//   ptr         : word index currently presented
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS = DMEM_DEFAULT_WORDS,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          halted,
  input  logic          dump_ready,
  output dump_state_t   state,
  output logic [AW-1:0] ptr
);

  dump_state_t   state_d;
  logic [AW-1:0] ptr_d;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        if (halted) state_d = DUMP;
      end
      DUMP: begin
        if (dump_ready) begin
          ptr_d = ptr + AW'(1);
          if (ptr == AW'(WORDS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core.
// Combinational reads, clocked full-word writes (aligned only), sticky
// misaligned-write flag, and an optional post-halt memory dump.
// Build option: define DMEM_DUMP_EN to include the dump engine; without it
// the dump outputs are tied off and dump_done is a registered copy of halted.
// Ports:
//   clk, rst_b   : clock, synchronous active-high reset
//   bus          : core data port + dump port (slave modport)
//   halted       : core halt level; blocks writes, starts the dump
//   misalign_err : sticky, set by a write strobe to a non-word-aligned address
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS = DMEM_DEFAULT_WORDS,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  data_mem_responder_if.slave  bus,
  input  logic                 halted,
  output logic                 misalign_err
);

  byte_lanes_t   mem [WORDS];
  logic [AW-1:0] idx;

  // Upper address bits only alias; they carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr[31:AW+2];

  assign idx              = bus.mem_addr[AW+1:2];
  assign bus.mem_data_out = mem[idx];

  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
      misalign_err <= 1'b0;
    end else if (bus.mem_write_en && !halted) begin
      if (bus.mem_addr[1:0] == 2'b00) mem[idx] <= bus.mem_data_in;
      else                            misalign_err <= 1'b1;
    end
  end

`ifdef DMEM_DUMP_EN
  dump_state_t   state;
  logic [AW-1:0] ptr;

  dmem_dump_fsm #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_dump_fsm (
    .clk        (clk),
    .rst_b      (rst_b),
    .halted     (halted),
    .dump_ready (bus.dump_ready),
    .state      (state),
    .ptr        (ptr)
  );

  always_comb begin
    bus.dump_addr            = '0;
    bus.dump_addr[AW+1:0]    = {ptr, 2'b00};
    bus.dump_data            = mem[ptr];
    bus.dump_valid           = (state == DUMP);
    bus.dump_done            = (state == DONE);
  end
`else
  logic dump_done_q;
  logic unused_dump_ready;

  assign unused_dump_ready = bus.dump_ready;

  always_ff @(posedge clk) begin
    if (rst_b) dump_done_q <= 1'b0;
    else       dump_done_q <= halted;
  end

  assign bus.dump_valid = 1'b0;
  assign bus.dump_addr  = '0;
  assign bus.dump_data  = '0;
  assign bus.dump_done  = dump_done_q;
`endif

endmodule
